// File: rtl/hm_scan_ctrl.sv
// Host-memory scan scheduler: walks an address window in CHUNK_BYTES steps,
// issuing one read request per chunk and waiting for its completion.
module hm_scan_ctrl #(
  parameter int          CHUNK_BYTES    = 4096,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'h0800_0000
) (
  input  logic        trn_clk,
  input  logic        sys_rst,
  input  logic        cfg_start,
  input  logic        cfg_stop,
  input  logic        cfg_loop,
  input  logic [63:0] cfg_addr_start,
  input  logic [63:0] cfg_addr_end,
  output logic        tx_start,
  output logic [63:0] hm_addr,
  input  logic        tx_end,
  input  logic        rx_end,
  output logic        busy,
  output logic        done,
  output logic [31:0] stat_req_cnt,
  output logic [31:0] stat_scan_cnt,
  output logic [31:0] stat_timeout_cnt,
  output logic [2:0]  stat_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_TX = 3'd2,
    WAIT_RX = 3'd3,
    NEXT    = 3'd4
  } state_t;

  localparam logic [63:0] LOW_MASK  = 64'(CHUNK_BYTES) - 64'd1;
  localparam logic [64:0] CHUNK_INC = 65'(CHUNK_BYTES);

  state_t      state;
  state_t      state_nxt;
  logic [63:0] base_q;
  logic [63:0] end_q;
  logic [63:0] cur;
  logic        stop_pend;
  logic        rx_seen;
  logic [31:0] wd;

  logic [63:0] aligned_start;
  logic        win_ok;
  logic [64:0] nxt_sum;
  logic        win_over;
  logic        waiting;
  logic        timeout_hit;

  logic        tx_start_d;
  logic        done_d;
  logic        req_inc;
  logic        scan_inc;
  logic        to_inc;

  assign aligned_start = cfg_addr_start & ~LOW_MASK;
  assign win_ok        = aligned_start < cfg_addr_end;
  // 65-bit sum so a window ending near 2^64 terminates instead of wrapping to 0
  assign nxt_sum       = {1'b0, cur} + CHUNK_INC;
  assign win_over      = nxt_sum[64] || (nxt_sum >= {1'b0, end_q});
  assign waiting       = (state == WAIT_TX) || (state == WAIT_RX);
  assign timeout_hit   = waiting && (wd == TIMEOUT_CYCLES);
  assign stat_state    = state;

  always_ff @(posedge trn_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_start && win_ok) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT_TX;
      WAIT_TX: begin
        if (timeout_hit)                      state_nxt = NEXT;
        else if (tx_end && (rx_seen || rx_end)) state_nxt = NEXT;
        else if (tx_end)                      state_nxt = WAIT_RX;
      end
      WAIT_RX: if (rx_end || rx_seen || timeout_hit) state_nxt = NEXT;
      NEXT: begin
        if (stop_pend)     state_nxt = IDLE;
        else if (win_over) state_nxt = cfg_loop ? ISSUE : IDLE;
        else               state_nxt = ISSUE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_start_d = 1'b0;
    done_d     = 1'b0;
    req_inc    = 1'b0;
    scan_inc   = 1'b0;
    to_inc     = 1'b0;
    case (state)
      IDLE:    done_d = cfg_start && !win_ok;
      ISSUE: begin
        tx_start_d = 1'b1;
        req_inc    = 1'b1;
      end
      WAIT_TX: to_inc = timeout_hit;
      // a completion arriving on the timeout cycle wins
      WAIT_RX: to_inc = timeout_hit && !(rx_end || rx_seen);
      NEXT: begin
        done_d   = (state_nxt == IDLE);
        scan_inc = !stop_pend && win_over;
      end
      default: ;
    endcase
  end

  always_ff @(posedge trn_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tx_start         <= 1'b0;
      hm_addr          <= 64'd0;
      busy             <= 1'b0;
      done             <= 1'b0;
      stat_req_cnt     <= 32'd0;
      stat_scan_cnt    <= 32'd0;
      stat_timeout_cnt <= 32'd0;
      stop_pend        <= 1'b0;
      rx_seen          <= 1'b0;
      wd               <= 32'd0;
    end else begin
      tx_start <= tx_start_d;
      done     <= done_d;
      busy     <= (state_nxt != IDLE);
      if (state == ISSUE) hm_addr <= cur;
      if (req_inc)  stat_req_cnt     <= stat_req_cnt + 32'd1;
      if (scan_inc) stat_scan_cnt    <= stat_scan_cnt + 32'd1;
      if (to_inc)   stat_timeout_cnt <= stat_timeout_cnt + 32'd1;
      if (state == IDLE)  stop_pend <= 1'b0;
      else if (cfg_stop)  stop_pend <= 1'b1;
      if (state == IDLE || state == NEXT)    rx_seen <= 1'b0;
      else if (state == WAIT_TX && rx_end)   rx_seen <= 1'b1;
      wd <= waiting ? wd + 32'd1 : 32'd0;
    end
  end

  always_ff @(posedge trn_clk) begin
    if (state == IDLE && cfg_start && win_ok) begin
      base_q <= aligned_start;
      end_q  <= cfg_addr_end;
      cur    <= aligned_start;
    end else if (state == NEXT && !stop_pend) begin
      cur <= win_over ? base_q : nxt_sum[63:0];
    end
  end

endmodule

// File: tb/tb_hm_scan_ctrl.sv
// Bench for hm_scan_ctrl: a responder answers each request after programmable
// delays; results are compared against a window-arithmetic reference model.
module tb_hm_scan_ctrl;
  localparam int CHUNK = 4096;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic        cfg_stop = 1'b0;
  logic        cfg_loop = 1'b0;
  logic [63:0] cfg_addr_start = 64'd0;
  logic [63:0] cfg_addr_end = 64'd0;
  logic        tx_end = 1'b0;
  logic        rx_end = 1'b0;
  logic        tx_start;
  logic [63:0] hm_addr;
  logic        busy;
  logic        done;
  logic [31:0] stat_req_cnt;
  logic [31:0] stat_scan_cnt;
  logic [31:0] stat_timeout_cnt;
  logic [2:0]  stat_state;

  int nvec = 0;
  int nerr = 0;
  int tx_dly = 2;
  int rx_dly = 7;
  bit tx_en = 1'b1;
  bit rx_en = 1'b1;
  logic [63:0] addr_q[$];
  int stamp_q[$];
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int start_cyc = 0;
  logic [31:0] exp_req = 0;
  logic [31:0] exp_scan = 0;
  logic [31:0] exp_to = 0;

  hm_scan_ctrl #(.CHUNK_BYTES(CHUNK), .TIMEOUT_CYCLES(32'(TMO))) dut (
    .trn_clk(clk), .sys_rst(rst), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_loop(cfg_loop), .cfg_addr_start(cfg_addr_start), .cfg_addr_end(cfg_addr_end),
    .tx_start(tx_start), .hm_addr(hm_addr), .tx_end(tx_end), .rx_end(rx_end),
    .busy(busy), .done(done), .stat_req_cnt(stat_req_cnt), .stat_scan_cnt(stat_scan_cnt),
    .stat_timeout_cnt(stat_timeout_cnt), .stat_state(stat_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) begin
    done_cnt      = done_cnt + 1;
    last_done_cyc = cyc;
  end

  // Transmitter/completion responder
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        int lim;
        addr_q.push_back(hm_addr);
        stamp_q.push_back(cyc);
        lim = (tx_dly > rx_dly) ? tx_dly : rx_dly;
        for (int c = 1; c <= lim; c++) begin
          @(negedge clk);
          tx_end = tx_en && (c == tx_dly);
          rx_end = rx_en && (c == rx_dly);
        end
        @(negedge clk);
        tx_end = 1'b0;
        rx_end = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running, required to finish");
    $fatal(1);
  end

  function automatic int model_nreq(logic [63:0] b, logic [63:0] e);
    logic [64:0] ab;
    ab = {1'b0, b & ~(64'(CHUNK) - 64'd1)};
    if (ab >= {1'b0, e}) return 0;
    return int'(({1'b0, e} - ab + 65'(CHUNK - 1)) / 65'(CHUNK));
  endfunction

  function automatic logic [63:0] model_addr(logic [63:0] b, int n, int i);
    return (b & ~(64'(CHUNK) - 64'd1)) + 64'(i % n) * 64'(CHUNK);
  endfunction

  task automatic start_scan(input logic [63:0] b, input logic [63:0] e, input logic lp,
                            input int td, input int rd, input bit ten, input bit ren);
    tx_dly = td; rx_dly = rd; tx_en = ten; rx_en = ren;
    @(negedge clk);
    addr_q.delete();
    stamp_q.delete();
    cfg_addr_start = b; cfg_addr_end = e; cfg_loop = lp;
    cfg_start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      if (done_cnt != d0) seen = 1'b1;
    end
    repeat (3) @(negedge clk);
    nvec++;
    if (!seen) begin
      nerr++;
      $display("FAIL %s_done_wait: no done pulse, required one within 3000 cycles", tag);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    nvec++;
    if ({tx_start, busy, done, stat_state, hm_addr, stat_req_cnt, stat_scan_cnt,
         stat_timeout_cnt} !== '0) begin
      nerr++;
      $display("FAIL reset_values: got %h, expected 0",
               {tx_start, busy, done, stat_state, hm_addr, stat_req_cnt, stat_scan_cnt, stat_timeout_cnt});
    end
    rst = 1'b0;
    exp_req = 0; exp_scan = 0; exp_to = 0;
    cfg_stop = 1'b1;
    @(negedge clk);
    cfg_stop = 1'b0;
    repeat (3) @(negedge clk);
    nvec++;
    if ({tx_start, busy, done, stat_state} !== 6'd0 || addr_q.size() != 0) begin
      nerr++;
      $display("FAIL idle_after_reset: got %b reqs=%0d, expected 0 reqs=0",
               {tx_start, busy, done, stat_state}, addr_q.size());
    end
  endtask

  task automatic test_basic_scan();
    logic [63:0] b = 64'h1000;
    logic [63:0] e = 64'h4000;
    int n, d0, turn;
    n = model_nreq(b, e);
    d0 = done_cnt;
    start_scan(b, e, 1'b0, 2, 7, 1'b1, 1'b1);
    wait_done(d0, "basic");
    exp_req += 32'(n); exp_scan += 32'd1;
    turn = 7 + 1;
    nvec++;
    if (addr_q.size() != n) begin
      nerr++; $display("FAIL basic_nreq: got %0d, expected %0d", addr_q.size(), n);
    end
    for (int i = 0; i < addr_q.size() && i < n; i++) begin
      nvec++;
      if (addr_q[i] !== model_addr(b, n, i)) begin
        nerr++; $display("FAIL basic_addr[%0d]: got %h, expected %h", i, addr_q[i], model_addr(b, n, i));
      end
    end
    nvec++;
    if (stamp_q.size() == 0 || stamp_q[0] - start_cyc != 2) begin
      nerr++; $display("FAIL basic_start_latency: got %0d, expected 2",
                       stamp_q.size() ? stamp_q[0] - start_cyc : -1);
    end
    for (int i = 1; i < stamp_q.size(); i++) begin
      nvec++;
      if (stamp_q[i] - stamp_q[i-1] != turn + 2) begin
        nerr++; $display("FAIL basic_turnaround[%0d]: got %0d, expected %0d", i, stamp_q[i] - stamp_q[i-1], turn + 2);
      end
    end
    nvec++;
    if (stamp_q.size() == 0 || last_done_cyc - stamp_q[stamp_q.size()-1] != turn + 1) begin
      nerr++; $display("FAIL basic_done_latency: got %0d, expected %0d",
                       stamp_q.size() ? last_done_cyc - stamp_q[stamp_q.size()-1] : -1, turn + 1);
    end
    nvec++;
    if (stat_req_cnt !== exp_req || stat_scan_cnt !== exp_scan || stat_timeout_cnt !== exp_to) begin
      nerr++; $display("FAIL basic_stats: got %0d/%0d/%0d, expected %0d/%0d/%0d", stat_req_cnt,
                       stat_scan_cnt, stat_timeout_cnt, exp_req, exp_scan, exp_to);
    end
    nvec++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      nerr++; $display("FAIL basic_done_busy: got done=%0d busy=%b, expected done=1 busy=0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_unaligned();
    int d0;
    d0 = done_cnt;
    start_scan(64'h1234_5678, 64'h1234_6000, 1'b0, 3, 3, 1'b1, 1'b1);
    wait_done(d0, "unaligned");
    exp_req += 32'(model_nreq(64'h1234_5678, 64'h1234_6000)); exp_scan += 32'd1;
    nvec++;
    if (addr_q.size() != 1 || addr_q[0] !== 64'h1234_5000) begin
      nerr++; $display("FAIL unaligned_addr: got n=%0d first=%h, expected n=1 first=0000000012345000",
                       addr_q.size(), addr_q.size() ? addr_q[0] : 64'd0);
    end
    nvec++;
    if (stat_req_cnt !== exp_req || stat_scan_cnt !== exp_scan) begin
      nerr++; $display("FAIL unaligned_stats: got %0d/%0d, expected %0d/%0d", stat_req_cnt, stat_scan_cnt, exp_req, exp_scan);
    end
  endtask

  task automatic test_empty_window();
    logic [63:0] bs[2] = '{64'h8000, 64'h8123};
    int d0;
    for (int t = 0; t < 2; t++) begin
      d0 = done_cnt;
      start_scan(bs[t], 64'h8000, 1'b0, 2, 2, 1'b1, 1'b1);
      wait_done(d0, "empty");
      nvec++;
      if (addr_q.size() != 0 || stat_req_cnt !== exp_req || done_cnt - d0 != 1 || busy !== 1'b0) begin
        nerr++; $display("FAIL empty_window[%0d]: got reqs=%0d cnt=%0d done=%0d busy=%b, expected 0/%0d/1/0",
                         t, addr_q.size(), stat_req_cnt, done_cnt - d0, busy, exp_req);
      end
    end
  endtask

  task automatic test_timeout();
    int d0, n;
    n = model_nreq(64'h10000, 64'h12000);
    d0 = done_cnt;
    start_scan(64'h10000, 64'h12000, 1'b0, 2, 2, 1'b0, 1'b0);
    wait_done(d0, "timeout");
    exp_req += 32'(n); exp_scan += 32'd1; exp_to += 32'(n);
    nvec++;
    if (stat_timeout_cnt !== exp_to || stat_req_cnt !== exp_req || stat_scan_cnt !== exp_scan) begin
      nerr++; $display("FAIL timeout_stats: got to=%0d req=%0d scan=%0d, expected %0d/%0d/%0d",
                       stat_timeout_cnt, stat_req_cnt, stat_scan_cnt, exp_to, exp_req, exp_scan);
    end
    nvec++;
    if (stamp_q.size() != 2 || stamp_q[1] - stamp_q[0] != TMO + 3) begin
      nerr++; $display("FAIL timeout_spacing: got n=%0d gap=%0d, expected n=2 gap=%0d",
                       stamp_q.size(), stamp_q.size() == 2 ? stamp_q[1] - stamp_q[0] : -1, TMO + 3);
    end
    nvec++;
    if (stamp_q.size() == 0 || last_done_cyc - stamp_q[stamp_q.size()-1] != TMO + 2) begin
      nerr++; $display("FAIL timeout_done_latency: got %0d, expected %0d",
                       stamp_q.size() ? last_done_cyc - stamp_q[stamp_q.size()-1] : -1, TMO + 2);
    end
  endtask

  task automatic test_stop_loop();
    logic [63:0] b = 64'h20000;
    int d0, k, n;
    bit hit = 1'b0;
    n = model_nreq(b, 64'h22000);
    d0 = done_cnt;
    start_scan(b, 64'h22000, 1'b1, 2, 7, 1'b1, 1'b1);
    for (k = 0; k < 500 && !hit; k++) begin
      @(negedge clk);
      if (addr_q.size() >= 5 && stat_state === 3'd3) hit = 1'b1;
    end
    nvec++;
    if (!hit) begin
      nerr++; $display("FAIL stop_reach_5th: got reqs=%0d state=%0d, expected 5th request in WAIT_RX", addr_q.size(), stat_state);
    end
    cfg_stop = 1'b1;
    @(negedge clk);
    cfg_stop = 1'b0;
    wait_done(d0, "stop");
    repeat (20) @(negedge clk);
    exp_req += 32'd5; exp_scan += 32'd2;
    nvec++;
    if (addr_q.size() != 5) begin
      nerr++; $display("FAIL stop_nreq: got %0d, expected 5", addr_q.size());
    end
    for (int i = 0; i < addr_q.size(); i++) begin
      nvec++;
      if (addr_q[i] !== model_addr(b, n, i)) begin
        nerr++; $display("FAIL stop_addr[%0d]: got %h, expected %h", i, addr_q[i], model_addr(b, n, i));
      end
    end
    nvec++;
    if (stamp_q.size() == 0 || last_done_cyc - stamp_q[stamp_q.size()-1] != 7 + 2) begin
      nerr++; $display("FAIL stop_completion_honoured: got %0d, expected 9",
                       stamp_q.size() ? last_done_cyc - stamp_q[stamp_q.size()-1] : -1);
    end
    nvec++;
    if (stat_req_cnt !== exp_req || stat_scan_cnt !== exp_scan || done_cnt - d0 != 1 || busy !== 1'b0) begin
      nerr++; $display("FAIL stop_stats: got req=%0d scan=%0d done=%0d busy=%b, expected %0d/%0d/1/0",
                       stat_req_cnt, stat_scan_cnt, done_cnt - d0, busy, exp_req, exp_scan);
    end
  endtask

  task automatic test_overflow();
    logic [63:0] b = 64'hFFFF_FFFF_FFFF_E000;
    logic [63:0] e = 64'hFFFF_FFFF_FFFF_FFFF;
    int d0, n;
    n = model_nreq(b, e);
    d0 = done_cnt;
    start_scan(b, e, 1'b0, 1, 4, 1'b1, 1'b1);
    wait_done(d0, "overflow");
    exp_req += 32'(n); exp_scan += 32'd1;
    nvec++;
    if (addr_q.size() != n) begin
      nerr++; $display("FAIL overflow_nreq: got %0d, expected %0d", addr_q.size(), n);
    end
    for (int i = 0; i < addr_q.size() && i < n; i++) begin
      nvec++;
      if (addr_q[i] !== model_addr(b, n, i)) begin
        nerr++; $display("FAIL overflow_addr[%0d]: got %h, expected %h", i, addr_q[i], model_addr(b, n, i));
      end
    end
    nvec++;
    if (stat_req_cnt !== exp_req || stat_scan_cnt !== exp_scan || busy !== 1'b0) begin
      nerr++; $display("FAIL overflow_stats: got %0d/%0d busy=%b, expected %0d/%0d busy=0",
                       stat_req_cnt, stat_scan_cnt, busy, exp_req, exp_scan);
    end
  endtask

  task automatic test_reset_midrequest();
    int k, nq;
    start_scan(64'h40000, 64'h44000, 1'b0, 2, 2, 1'b0, 1'b0);
    k = 0;
    while (stat_state !== 3'd2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    nvec++;
    if (stat_state !== 3'd2 || hm_addr !== 64'h40000) begin
      nerr++; $display("FAIL rst_reach_wait_tx: got state=%0d addr=%h, expected 2/0000000000040000", stat_state, hm_addr);
    end
    cfg_addr_start = 64'h0; cfg_addr_end = 64'h1_0000; cfg_start = 1'b1;
    @(posedge clk);
    #2;
    cfg_start = 1'b0;
    rst = 1'b1;
    #1;
    nvec++;
    if ({tx_start, busy, done, stat_state, hm_addr, stat_req_cnt, stat_scan_cnt,
         stat_timeout_cnt} !== '0) begin
      nerr++;
      $display("FAIL rst_async_values: got %h, expected 0",
               {tx_start, busy, done, stat_state, hm_addr, stat_req_cnt, stat_scan_cnt, stat_timeout_cnt});
    end
    exp_req = 0; exp_scan = 0; exp_to = 0;
    @(negedge clk);
    rst = 1'b0;
    nq = addr_q.size();
    repeat (30) @(negedge clk);
    nvec++;
    if (addr_q.size() != nq || busy !== 1'b0 || stat_state !== 3'd0 || stat_req_cnt !== exp_req) begin
      nerr++; $display("FAIL rst_idle_after: got new_reqs=%0d busy=%b state=%0d req=%0d, expected 0/0/0/0",
                       addr_q.size() - nq, busy, stat_state, stat_req_cnt);
    end
  endtask

  task automatic test_random();
    logic [63:0] ab, b, e;
    int len, td, rd, n, d0, turn;
    for (int it = 0; it < 6; it++) begin
      ab  = {32'($urandom), 32'($urandom)} & 64'h7FFF_FFFF_FFFF_F000;
      b   = ab | 64'($urandom_range(0, CHUNK - 1));
      len = $urandom_range(0, 4);
      e   = (len == 0) ? ab : ab + 64'(len) * 64'(CHUNK) - 64'($urandom_range(0, CHUNK - 1));
      td  = $urandom_range(1, 6);
      rd  = $urandom_range(1, 8);
      n   = model_nreq(b, e);
      turn = ((td > rd) ? td : rd) + 1;
      d0  = done_cnt;
      start_scan(b, e, 1'b0, td, rd, 1'b1, 1'b1);
      wait_done(d0, "random");
      exp_req += 32'(n);
      if (n > 0) exp_scan += 32'd1;
      nvec++;
      if (addr_q.size() != n) begin
        nerr++; $display("FAIL rand%0d_nreq: got %0d, expected %0d", it, addr_q.size(), n);
      end
      for (int i = 0; i < addr_q.size() && i < n; i++) begin
        nvec++;
        if (addr_q[i] !== model_addr(b, n, i)) begin
          nerr++; $display("FAIL rand%0d_addr[%0d]: got %h, expected %h", it, i, addr_q[i], model_addr(b, n, i));
        end
      end
      for (int i = 1; i < stamp_q.size(); i++) begin
        nvec++;
        if (stamp_q[i] - stamp_q[i-1] != turn + 2) begin
          nerr++; $display("FAIL rand%0d_turnaround[%0d]: got %0d, expected %0d", it, i, stamp_q[i] - stamp_q[i-1], turn + 2);
        end
      end
      nvec++;
      if (stat_req_cnt !== exp_req || stat_scan_cnt !== exp_scan || stat_timeout_cnt !== exp_to ||
          done_cnt - d0 != 1 || busy !== 1'b0) begin
        nerr++; $display("FAIL rand%0d_stats: got %0d/%0d/%0d done=%0d busy=%b, expected %0d/%0d/%0d done=1 busy=0",
                         it, stat_req_cnt, stat_scan_cnt, stat_timeout_cnt, done_cnt - d0, busy,
                         exp_req, exp_scan, exp_to);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_unaligned();
    test_empty_window();
    test_timeout();
    test_stop_loop();
    test_overflow();
    test_reset_midrequest();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
